// File: rtl/ah_decode_req_scheduler.sv
// Round-robin request scheduler with a runtime [bom, tom] decode table.
// It issues one request at a time to the matching client, with ack and timeout.
module ah_decode_req_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_CLIENT = 8,
  parameter int ADDR_W     = 24,
  parameter int TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      cfg_we,
  input  logic [3:0]                cfg_idx,
  input  logic                      cfg_sel_top,
  input  logic [ADDR_W-1:0]         cfg_data,
  output logic [NUM_CLIENT-1:0]     cli_valid,
  output logic [ADDR_W-1:0]         cli_addr,
  input  logic [NUM_CLIENT-1:0]     cli_ack,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_id,
  output logic                      rsp_err,
  output logic [7:0]                err_cnt,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, DECODE, ISSUE, RESP} state_t;

  state_t                state_q, state_d;
  logic [2:0]            last_q, last_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2:0]            id_q, id_d;
  logic [3:0]            tgt_q, tgt_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     bom_q [NUM_CLIENT];
  logic [ADDR_W-1:0]     bom_d [NUM_CLIENT];
  logic [ADDR_W-1:0]     tom_q [NUM_CLIENT];
  logic [ADDR_W-1:0]     tom_d [NUM_CLIENT];
  logic [NUM_CLIENT-1:0] cli_valid_q, cli_valid_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [2:0]            rsp_id_q, rsp_id_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  busy_q, busy_d;

  logic                  gnt_found;
  logic [2:0]            gnt_idx;
  logic [ADDR_W-1:0]     gnt_addr;
  logic                  hit_found;
  logic [3:0]            hit_idx;

  // Out-of-range indices never match a loop index, so they are dropped naturally.
  always_comb begin
    bom_d = bom_q;
    tom_d = tom_q;
    if (cfg_we) begin
      for (int c = 0; c < NUM_CLIENT; c++) begin
        if (cfg_idx == 4'(c)) begin
          if (cfg_sel_top) tom_d[c] = cfg_data;
          else             bom_d[c] = cfg_data;
        end
      end
    end
  end

  // First pass looks above the last grant, second pass wraps to the lowest index.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_addr  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (3'(i) > last_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(i);
        gnt_addr  = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(i);
        gnt_addr  = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && gnt_found && (gnt_idx == 3'(i));
    end
  end

  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int c = 0; c < NUM_CLIENT; c++) begin
      if (!hit_found && (bom_q[c] <= addr_q) && (addr_q <= tom_q[c])) begin
        hit_found = 1'b1;
        hit_idx   = 4'(c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    id_d    = id_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          addr_d  = gnt_addr;
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (hit_found) begin
          tgt_d   = hit_idx;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end else begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      ISSUE: begin
        // An ack on the expiry cycle wins over the timeout.
        if (|(cli_ack & cli_valid_q)) begin
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int c = 0; c < NUM_CLIENT; c++) begin
      cli_valid_d[c] = (state_d == ISSUE) && (tgt_d == 4'(c));
    end
    rsp_valid_d = (state_d == RESP);
    rsp_id_d    = (state_d == RESP) ? id_d : 3'd0;
    rsp_err_d   = (state_d == RESP) && err_d;
    busy_d      = (state_d != IDLE);
    err_cnt_d   = err_cnt_q;
    if ((state_d == RESP) && err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= '0;
      addr_q      <= '0;
      id_q        <= '0;
      tgt_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      for (int c = 0; c < NUM_CLIENT; c++) begin
        bom_q[c] <= '1;
        tom_q[c] <= '0;
      end
      cli_valid_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      bom_q       <= bom_d;
      tom_q       <= tom_d;
      cli_valid_q <= cli_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign cli_valid = cli_valid_q;
  assign cli_addr  = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = busy_q;

endmodule
